keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Consumer end of the keypad scan interface. Accepts the one-cycle `key_code`/`data_ready` events from the matrix scanner.
- Buffers them in a small FIFO and assembles a multi-digit BCD number with edit keys (enter, backspace, clear).
- Presents the committed value to downstream logic (display/control) over a valid/ready handshake.

Parameters:
- NUM_DIGITS, 4, max BCD digits held in the entry register (1..8)
- FIFO_DEPTH, 4, key-event buffer depth (power of 2, ≥2)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_code  in  4  code from scanner, valid only when data_ready=1
- data_ready  in  1  single-cycle key event strobe; no backpressure possible
- entry_bcd  out  4*NUM_DIGITS  live entry register, digit 0 in [3:0]
- entry_len  out  4  digits currently entered (0..NUM_DIGITS)
- value_bcd  out  4*NUM_DIGITS  committed value, stable while value_valid=1
- value_valid  out  1  committed value available
- value_ready  in  1  downstream accepts value when valid&ready
- overflow  out  1  sticky: digit dropped because entry full; cleared by CLEAR key or commit
- fifo_drop  out  1  sticky: event lost because FIFO full; cleared only by reset

Behaviour:
- Reset (reset=0, async) values:
  - All outputs are 0.
  - FIFO is empty.
  - FSM is in IDLE.
- Key map (package constants):
  - 0–9 = digits
  - 10 = KEY_ENTER
  - 11 = KEY_BACK
  - 12 = KEY_CLEAR
  - 13–15 are ignored: popped and discarded, no effect.
- FIFO:
  - Push when data_ready=1.
  - If full, the event is discarded and fifo_drop is set.
  - Push and pop in the same cycle when full: the pop frees a slot, so the push succeeds.
- FSM states: IDLE, DECODE, COMMIT.
  - IDLE: if the FIFO is non-empty, pop the head into key_q and go to DECODE. Pop latency is 1 cycle.
  - DECODE, digit:
    - If entry_len<NUM_DIGITS: shift entry_bcd left one digit, insert the new digit at digit 0, and increment entry_len.
    - Otherwise set overflow and leave the register unchanged.
    - Return to IDLE.
  - DECODE, KEY_BACK: if entry_len>0, shift right one digit (zero-fill the MS digit) and decrement entry_len; otherwise no-op. Return to IDLE.
  - DECODE, KEY_CLEAR: zero entry_bcd and entry_len, clear overflow, go to IDLE.
  - DECODE, KEY_ENTER:
    - If entry_len==0, no-op and go to IDLE.
    - Else if value_valid=1 (previous value unconsumed), stay in DECODE (stall, key held) until it is consumed.
    - Else go to COMMIT.
  - COMMIT:
    - value_bcd <= entry_bcd and value_valid <= 1.
    - Zero entry_bcd and entry_len, clear overflow.
    - Go to IDLE.
    - Total latency from ENTER pop to value_valid=1 is 2 cycles.
- Handshake:
  - value_valid stays high and value_bcd stays frozen until the cycle where value_valid&value_ready. value_valid falls on the next edge.
  - value_ready while value_valid=0 has no effect.
- Stall behaviour: while DECODE is stalled, the FIFO keeps accepting events; fifo_drop is set if it overflows.
- Events are processed strictly in arrival order; one key is processed per ≥2 cycles.
- Reset mid-operation: FIFO contents, the partial entry and any uncommitted value are all lost.

Optional Feature:
- Macro: KEYPAD_ENTRY_BIN_EN.
- When defined:
  - Adds output ports value_bin (ceil(log2(10^NUM_DIGITS)) bits) and bin_valid (1).
  - COMMIT is followed by state CONVERT, which runs NUM_DIGITS cycles of acc = acc*10 + digit, MS digit first.
  - value_valid and bin_valid both assert together when CONVERT completes, so latency from ENTER pop is 2+NUM_DIGITS cycles.
  - bin_valid clears with value_valid.
- When undefined: no extra ports, no CONVERT state, and latency is 2 cycles.

Decomposition:
- Package keypad_pkg:
  - KEY_ENTER/KEY_BACK/KEY_CLEAR constants
  - digit-range check function
  - FSM state typedef (IDLE, DECODE, COMMIT, CONVERT)
- Sub-module: keypad_event_fifo.
  - Synchronous FIFO, parameter FIFO_DEPTH, width 4.
  - Ports: push, din, pop, dout, empty, full.
  - fifo_drop logic lives in the parent.

Test Plan:
- Keys 1,2,3,ENTER (data_ready pulses 20 cycles apart), value_ready=1 → value_bcd=0x0123 and value_valid asserted 2 cycles after ENTER pop, high 1 cycle; entry_len returns to 0.
- Keys 9,8,7,6,5 then ENTER with NUM_DIGITS=4 → overflow=1 after the 5th key, value_bcd=0x9876, overflow cleared after commit.
- Keys 4,5,BACK,7,ENTER → value_bcd=0x0047; BACK with entry_len=0 → no change; ENTER alone → no value_valid.
- value_ready=0: keys 1,ENTER,2,ENTER → first value_bcd=0x0001 held; the second ENTER stalls until a value_ready pulse, then value_bcd=0x0002.
- Six data_ready pulses on consecutive cycles with FIFO_DEPTH=4 → the first ≥4 events are processed in order and fifo_drop=1.
- Drop reset low mid-entry (after keys 3,4) → all outputs 0 immediately (async); after release, keys 5,ENTER → value_bcd=0x0005. With KEYPAD_ENTRY_BIN_EN defined: keys 1,2,3,4,ENTER → value_bin=1234 and bin_valid asserted 6 cycles after ENTER pop.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key map, FSM state type and helpers for the keypad entry block.
// Imported by the FIFO and the entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_BACK  = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        COMMIT,
        CONVERT
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    // Bits needed to hold any n-digit decimal value: ceil(log2(10^n)).
    function automatic int bin_width(input int n);
        longint v;
        int w;
        v = 1;
        w = 0;
        for (int i = 0; i < n; i++) v = v * 10;
        for (int i = 0; i < 63; i++)
            if ((longint'(1) << i) < v) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Small synchronous FIFO buffering 4-bit key events.
// Head word is visible on dout whenever the FIFO is non-empty.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [3:0] din,
    input  logic       pop,
    output logic [3:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [3:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry controller: buffers scanner events, edits a BCD entry and
// hands committed values downstream. KEYPAD_ENTRY_BIN_EN adds binary output.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              key_code,
    input  logic                    data_ready,
    output logic [4*NUM_DIGITS-1:0] entry_bcd,
    output logic [3:0]              entry_len,
    output logic [4*NUM_DIGITS-1:0] value_bcd,
    output logic                    value_valid,
    input  logic                    value_ready,
    output logic                    overflow,
`ifdef KEYPAD_ENTRY_BIN_EN
    output logic [bin_width(NUM_DIGITS)-1:0] value_bin,
    output logic                    bin_valid,
`endif
    output logic                    fifo_drop
);

    localparam logic [3:0] MAX_LEN = 4'(NUM_DIGITS);

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              key_q;
    logic [3:0]              fifo_dout;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    logic                    push;
    logic                    shift_in;
    logic                    shift_back;
    logic                    clear_entry;
    logic                    commit;
    logic                    set_ovf;
    logic [4*NUM_DIGITS-1:0] ins_val;
    logic [4*NUM_DIGITS-1:0] back_val;

`ifdef KEYPAD_ENTRY_BIN_EN
    localparam int          BIN_W    = bin_width(NUM_DIGITS);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_DIGITS - 1);

    logic                   conv_step;
    logic [3:0]             conv_cnt;
    logic [3:0]             conv_digit;
    logic [BIN_W-1:0]       acc_nxt;
`endif

    // A full FIFO still accepts a push when the head is popped this cycle.
    assign push = data_ready && (!fifo_full || pop);

    keypad_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (key_code),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle action strobes for the edit datapath.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        shift_in    = 1'b0;
        shift_back  = 1'b0;
        clear_entry = 1'b0;
        commit      = 1'b0;
        set_ovf     = 1'b0;
`ifdef KEYPAD_ENTRY_BIN_EN
        conv_step   = 1'b0;
`endif
        ins_val       = entry_bcd << 4;
        ins_val[3:0]  = key_q;
        back_val      = entry_bcd >> 4;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = IDLE;
                unique case (1'b1)
                    is_digit(key_q): begin
                        if (entry_len < MAX_LEN) shift_in = 1'b1;
                        else                     set_ovf  = 1'b1;
                    end
                    key_q == KEY_BACK: begin
                        if (entry_len != 4'd0) shift_back = 1'b1;
                    end
                    key_q == KEY_CLEAR: begin
                        clear_entry = 1'b1;
                    end
                    key_q == KEY_ENTER: begin
                        if (entry_len != 4'd0) begin
                            if (value_valid) state_nxt = DECODE;
                            else             state_nxt = COMMIT;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            COMMIT: begin
                commit = 1'b1;
`ifdef KEYPAD_ENTRY_BIN_EN
                state_nxt = CONVERT;
`else
                state_nxt = IDLE;
`endif
            end
            CONVERT: begin
`ifdef KEYPAD_ENTRY_BIN_EN
                conv_step = 1'b1;
                if (conv_cnt == LAST_IDX) state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef KEYPAD_ENTRY_BIN_EN
    // Select the next BCD digit, most significant first, and fold it in.
    always_comb begin
        conv_digit = 4'(value_bcd >> {LAST_IDX - conv_cnt, 2'b00});
        acc_nxt    = value_bin * BIN_W'(10) + BIN_W'(conv_digit);
    end

    // Binary accumulator and digit counter for the conversion pass.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_bin <= '0;
            conv_cnt  <= '0;
            bin_valid <= 1'b0;
        end else begin
            if (value_valid && value_ready) bin_valid <= 1'b0;
            if (commit) begin
                value_bin <= '0;
                conv_cnt  <= '0;
            end
            if (conv_step) begin
                value_bin <= acc_nxt;
                conv_cnt  <= conv_cnt + 4'd1;
                if (conv_cnt == LAST_IDX) bin_valid <= 1'b1;
            end
        end
    end
`endif

    // Key capture, entry editing, commit and sticky status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_q       <= '0;
            entry_bcd   <= '0;
            entry_len   <= '0;
            value_bcd   <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
            fifo_drop   <= 1'b0;
        end else begin
            if (pop) key_q <= fifo_dout;
            if (data_ready && fifo_full && !pop) fifo_drop <= 1'b1;
            if (value_valid && value_ready) value_valid <= 1'b0;
            if (set_ovf) overflow <= 1'b1;
            if (shift_in) begin
                entry_bcd <= ins_val;
                entry_len <= entry_len + 4'd1;
            end
            if (shift_back) begin
                entry_bcd <= back_val;
                entry_len <= entry_len - 4'd1;
            end
            if (clear_entry || commit) begin
                entry_bcd <= '0;
                entry_len <= '0;
                overflow  <= 1'b0;
            end
            if (commit) value_bcd <= entry_bcd;
`ifdef KEYPAD_ENTRY_BIN_EN
            if (conv_step && conv_cnt == LAST_IDX) value_valid <= 1'b1;
`else
            if (commit) value_valid <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry.
// Build with KEYPAD_ENTRY_BIN_EN defined to cover the binary output.
module tb_keypad_entry;
    import keypad_pkg::*;

    localparam int ND = 4;
    localparam int FD = 4;
`ifdef KEYPAD_ENTRY_BIN_EN
    localparam int LAT = 2 + ND;
`else
    localparam int LAT = 2;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      key_code = 4'd0;
    logic            data_ready = 1'b0;
    logic            value_ready = 1'b0;
    logic [4*ND-1:0] entry_bcd;
    logic [3:0]      entry_len;
    logic [4*ND-1:0] value_bcd;
    logic            value_valid;
    logic            overflow;
    logic            fifo_drop;
`ifdef KEYPAD_ENTRY_BIN_EN
    logic [bin_width(ND)-1:0] value_bin;
    logic            bin_valid;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    keypad_entry #(
        .NUM_DIGITS(ND),
        .FIFO_DEPTH(FD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_code    (key_code),
        .data_ready  (data_ready),
        .entry_bcd   (entry_bcd),
        .entry_len   (entry_len),
        .value_bcd   (value_bcd),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .overflow    (overflow),
`ifdef KEYPAD_ENTRY_BIN_EN
        .value_bin   (value_bin),
        .bin_valid   (bin_valid),
`endif
        .fifo_drop   (fifo_drop)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_code   = k;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        key_code   = 4'd0;
    endtask

    task automatic key(input logic [3:0] k);
        press(k);
        wait_cycles(19);
    endtask

    task automatic accept();
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;
    endtask

    initial begin
        logic seen;

        // Reset state
        #12;
        check("rst_entry_bcd", 32'(entry_bcd), 32'h0);
        check("rst_entry_len", 32'(entry_len), 32'h0);
        check("rst_value_bcd", 32'(value_bcd), 32'h0);
        check("rst_value_valid", 32'(value_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_fifo_drop", 32'(fifo_drop), 32'h0);
`ifdef KEYPAD_ENTRY_BIN_EN
        check("rst_value_bin", 32'(value_bin), 32'h0);
        check("rst_bin_valid", 32'(bin_valid), 32'h0);
`endif
        reset = 1'b1;
        wait_cycles(3);

        // 1,2,3,ENTER with ready held high: check latency and one-cycle valid
        key(4'd1);
        key(4'd2);
        key(4'd3);
        check("t1_entry_bcd", 32'(entry_bcd), 32'h0123);
        check("t1_entry_len", 32'(entry_len), 32'd3);
        value_ready = 1'b1;
        press(KEY_ENTER);
        wait_cycles(LAT);
        check("t1_valid_early", 32'(value_valid), 32'h0);
        tick();
        check("t1_valid", 32'(value_valid), 32'h1);
        check("t1_value_bcd", 32'(value_bcd), 32'h0123);
        check("t1_len_zero", 32'(entry_len), 32'd0);
`ifdef KEYPAD_ENTRY_BIN_EN
        check("t1_bin_valid", 32'(bin_valid), 32'h1);
        check("t1_value_bin", 32'(value_bin), 32'd123);
`endif
        tick();
        check("t1_valid_fall", 32'(value_valid), 32'h0);
        value_ready = 1'b0;
        wait_cycles(10);

        // Overflow on fifth digit, cleared by commit
        key(4'd9);
        key(4'd8);
        key(4'd7);
        key(4'd6);
        check("t2_no_ovf", 32'(overflow), 32'h0);
        key(4'd5);
        check("t2_ovf", 32'(overflow), 32'h1);
        check("t2_entry_bcd", 32'(entry_bcd), 32'h9876);
        check("t2_entry_len", 32'(entry_len), 32'd4);
        key(KEY_ENTER);
        check("t2_valid", 32'(value_valid), 32'h1);
        check("t2_value_bcd", 32'(value_bcd), 32'h9876);
        check("t2_ovf_clr", 32'(overflow), 32'h0);
        check("t2_len_zero", 32'(entry_len), 32'd0);
        accept();
        check("t2_valid_fall", 32'(value_valid), 32'h0);

        // Backspace editing, backspace on empty, enter on empty
        key(4'd4);
        key(4'd5);
        key(KEY_BACK);
        check("t3_back_bcd", 32'(entry_bcd), 32'h0004);
        check("t3_back_len", 32'(entry_len), 32'd1);
        key(4'd7);
        key(KEY_ENTER);
        check("t3_value_bcd", 32'(value_bcd), 32'h0047);
        accept();
        key(KEY_BACK);
        check("t3_empty_back_bcd", 32'(entry_bcd), 32'h0);
        check("t3_empty_back_len", 32'(entry_len), 32'd0);
        press(KEY_ENTER);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (value_valid) seen = 1'b1;
            tick();
        end
        check("t3_empty_enter", 32'(seen), 32'h0);

        // Second ENTER stalls behind an unconsumed value
        key(4'd1);
        key(KEY_ENTER);
        check("t4_first_valid", 32'(value_valid), 32'h1);
        check("t4_first_bcd", 32'(value_bcd), 32'h0001);
        key(4'd2);
        key(KEY_ENTER);
        check("t4_held_bcd", 32'(value_bcd), 32'h0001);
        check("t4_stall_len", 32'(entry_len), 32'd1);
        check("t4_stall_entry", 32'(entry_bcd), 32'h0002);
        accept();
        check("t4_valid_fall", 32'(value_valid), 32'h0);
        wait_cycles(LAT - 1);
        check("t4_valid_early", 32'(value_valid), 32'h0);
        tick();
        check("t4_second_valid", 32'(value_valid), 32'h1);
        check("t4_second_bcd", 32'(value_bcd), 32'h0002);
        accept();

        // Burst into a stalled pipeline overflows the FIFO
        key(4'd9);
        key(KEY_ENTER);
        key(4'd8);
        key(KEY_ENTER);
        check("t5_no_drop", 32'(fifo_drop), 32'h0);
        for (int i = 1; i <= 6; i++) press(4'(i));
        check("t5_drop", 32'(fifo_drop), 32'h1);
        wait_cycles(10);
        check("t5_stalled_bcd", 32'(value_bcd), 32'h0009);
        check("t5_stalled_entry", 32'(entry_bcd), 32'h0008);
        accept();
        wait_cycles(LAT + 2);
        check("t5_commit_valid", 32'(value_valid), 32'h1);
        check("t5_commit_bcd", 32'(value_bcd), 32'h0008);
        accept();
        wait_cycles(20);
        check("t5_order_bcd", 32'(entry_bcd), 32'h1234);
        check("t5_order_len", 32'(entry_len), 32'd4);
        check("t5_order_ovf", 32'(overflow), 32'h0);
        check("t5_drop_sticky", 32'(fifo_drop), 32'h1);
        key(KEY_CLEAR);
        check("t5_clear_bcd", 32'(entry_bcd), 32'h0);
        check("t5_clear_len", 32'(entry_len), 32'd0);

        // Asynchronous reset mid-entry, then normal use afterwards
        key(4'd3);
        key(4'd4);
        check("t6_pre_bcd", 32'(entry_bcd), 32'h0034);
        #3;
        reset = 1'b0;
        #1;
        check("t6_rst_entry", 32'(entry_bcd), 32'h0);
        check("t6_rst_len", 32'(entry_len), 32'd0);
        check("t6_rst_value", 32'(value_bcd), 32'h0);
        check("t6_rst_valid", 32'(value_valid), 32'h0);
        check("t6_rst_drop", 32'(fifo_drop), 32'h0);
        check("t6_rst_ovf", 32'(overflow), 32'h0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(2);
        key(4'd5);
        key(KEY_ENTER);
        check("t6_valid", 32'(value_valid), 32'h1);
        check("t6_value_bcd", 32'(value_bcd), 32'h0005);
        accept();

`ifdef KEYPAD_ENTRY_BIN_EN
        // Binary conversion of a full entry
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        press(KEY_ENTER);
        wait_cycles(LAT);
        check("t7_bin_early", 32'(bin_valid), 32'h0);
        tick();
        check("t7_bin_valid", 32'(bin_valid), 32'h1);
        check("t7_value_valid", 32'(value_valid), 32'h1);
        check("t7_value_bin", 32'(value_bin), 32'd1234);
        accept();
        check("t7_bin_fall", 32'(bin_valid), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
